// File: rtl/probe_capture_if.sv
// Bus bundle for the probe_capture core. It carries the probe, the trigger setup,
// the capture status and the addressed readout port.
interface probe_capture_if #(
    parameter int WIDTH = 64,
    parameter int AW    = 8
);
    logic [WIDTH-1:0] probe_i;
    logic             arm_i;
    logic [WIDTH-1:0] trig_mask_i;
    logic [WIDTH-1:0] trig_value_i;
    logic [1:0]       trig_mode_i;
    logic [7:0]       trig_count_i;
    logic [2:0]       state_o;
    logic             triggered_o;
    logic             done_o;
    logic [AW-1:0]    trig_addr_o;
    logic             rd_en_i;
    logic [AW-1:0]    rd_addr_i;
    logic [WIDTH-1:0] rd_data_o;
    logic             rd_valid_o;

    modport master (
        output probe_i, arm_i, trig_mask_i, trig_value_i, trig_mode_i, trig_count_i,
               rd_en_i, rd_addr_i,
        input  state_o, triggered_o, done_o, trig_addr_o, rd_data_o, rd_valid_o
    );

    modport slave (
        input  probe_i, arm_i, trig_mask_i, trig_value_i, trig_mode_i, trig_count_i,
               rd_en_i, rd_addr_i,
        output state_o, triggered_o, done_o, trig_addr_o, rd_data_o, rd_valid_o
    );
endinterface

// File: rtl/probe_capture.sv
// Logic-analyser capture core. It writes the probe bus into a circular RAM, waits for a masked
// trigger on its Nth occurrence, and then freezes a window of PRE_DEPTH samples before the trigger.
module probe_capture #(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 256,
    parameter int PRE_DEPTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    probe_capture_if.slave bus
);
    localparam int AW       = $clog2(DEPTH);
    localparam int POST_LEN = DEPTH - PRE_DEPTH - 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_POST = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [AW-1:0] PRE_LAST  = AW'(PRE_DEPTH == 0 ? 0 : PRE_DEPTH - 1);
    localparam logic [AW-1:0] POST_LAST = AW'(POST_LEN == 0 ? 0 : POST_LEN - 1);

    logic [2:0]       state;
    logic [AW-1:0]    wptr, cnt, start, trig_addr;
    logic [7:0]       evt_cnt;
    logic [WIDTH-1:0] prev;
    logic             first_smp, wait_first;
    logic             triggered, done, rd_valid;
    logic [WIDTH-1:0] ram_q;
    logic [7:0]       need;
    logic             qual, fire, we, rd_fire;

    logic [WIDTH-1:0] mem [DEPTH];

    always_comb begin
        // NOTE: qual gets a default before the case so that no path leaves it unassigned and no latch is inferred.
        qual = 1'b0;
        case (bus.trig_mode_i)
            2'd0:    qual = (bus.probe_i & bus.trig_mask_i) == (bus.trig_value_i & bus.trig_mask_i);
            2'd1:    qual = !first_smp && |(~prev & bus.probe_i & bus.trig_mask_i);
            2'd2:    qual = !first_smp && |((prev ^ bus.probe_i) & bus.trig_mask_i);
            default: qual = wait_first;
        endcase
    end

    assign need    = (bus.trig_count_i == 8'd0) ? 8'd1 : bus.trig_count_i;
    assign fire    = (state == S_WAIT) && qual && (({1'b0, evt_cnt} + 9'd1) == {1'b0, need});
    assign we      = !bus.arm_i && (state == S_PRE || state == S_WAIT || state == S_POST);
    assign rd_fire = bus.rd_en_i && (state == S_DONE);

    // NOTE: nonblocking assignments here so that every register samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            wptr       <= '0;
            cnt        <= '0;
            start      <= '0;
            trig_addr  <= '0;
            evt_cnt    <= '0;
            prev       <= '0;
            first_smp  <= 1'b0;
            wait_first <= 1'b0;
            triggered  <= 1'b0;
            done       <= 1'b0;
            rd_valid   <= 1'b0;
        end else begin
            prev     <= bus.probe_i;
            rd_valid <= rd_fire;
            if (bus.arm_i) begin
                // An arm from any state restarts the capture. The arm cycle itself writes nothing.
                state      <= (PRE_DEPTH == 0) ? S_WAIT : S_PRE;
                wptr       <= '0;
                cnt        <= '0;
                evt_cnt    <= '0;
                first_smp  <= 1'b1;
                wait_first <= (PRE_DEPTH == 0);
                triggered  <= 1'b0;
                done       <= 1'b0;
                trig_addr  <= '0;
            end else begin
                if (we) begin
                    wptr      <= wptr + AW'(1);
                    first_smp <= 1'b0;
                end
                case (state)
                    S_PRE: begin
                        if (cnt == PRE_LAST) begin
                            state      <= S_WAIT;
                            cnt        <= '0;
                            wait_first <= 1'b1;
                        end else begin
                            cnt <= cnt + AW'(1);
                        end
                    end
                    S_WAIT: begin
                        wait_first <= 1'b0;
                        if (qual) evt_cnt <= evt_cnt + 8'd1;
                        if (fire) begin
                            start     <= wptr - AW'(PRE_DEPTH);
                            trig_addr <= AW'(PRE_DEPTH);
                            triggered <= 1'b1;
                            cnt       <= '0;
                            if (POST_LEN == 0) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= S_POST;
                            end
                        end
                    end
                    S_POST: begin
                        if (cnt == POST_LAST) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            cnt <= cnt + AW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: the sample RAM has no reset, so that it can map onto block RAM. Reads are gated by state instead.
    always_ff @(posedge clk) begin
        if (we) mem[wptr] <= bus.probe_i;
        if (rd_fire) ram_q <= mem[start + bus.rd_addr_i];
    end

    assign bus.state_o     = state;
    assign bus.triggered_o = triggered;
    assign bus.done_o      = done;
    assign bus.trig_addr_o = trig_addr;
    assign bus.rd_valid_o  = rd_valid;
    assign bus.rd_data_o   = rd_valid ? ram_q : '0;
endmodule

// File: tb/tb_probe_capture.sv
// Self-checking bench for probe_capture. Two instances, PRE_DEPTH 4 and 0, receive the same stimulus.
// Each instance is compared against a sample-history reference model.
module tb_probe_capture;
    localparam int W = 8, D = 16, A = 4, PRE0 = 4, PRE1 = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0] probe, mask, value, tcount;
    logic [1:0] mode;
    logic       arm, rd_en;
    logic [3:0] rd_addr;
    int         pgen;
    bit         rd_rand;
    int         n_cmp = 0, n_bad = 0;

    probe_capture_if #(.WIDTH(W), .AW(A)) bus0 ();
    probe_capture_if #(.WIDTH(W), .AW(A)) bus1 ();

    assign bus0.probe_i      = probe;   assign bus1.probe_i      = probe;
    assign bus0.arm_i        = arm;     assign bus1.arm_i        = arm;
    assign bus0.trig_mask_i  = mask;    assign bus1.trig_mask_i  = mask;
    assign bus0.trig_value_i = value;   assign bus1.trig_value_i = value;
    assign bus0.trig_mode_i  = mode;    assign bus1.trig_mode_i  = mode;
    assign bus0.trig_count_i = tcount;  assign bus1.trig_count_i = tcount;
    assign bus0.rd_en_i      = rd_en;   assign bus1.rd_en_i      = rd_en;
    assign bus0.rd_addr_i    = rd_addr; assign bus1.rd_addr_i    = rd_addr;

    probe_capture #(.WIDTH(W), .DEPTH(D), .PRE_DEPTH(PRE0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    probe_capture #(.WIDTH(W), .DEPTH(D), .PRE_DEPTH(PRE1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    // Reference model. Each instance keeps every sample written since the last arm.
    // The window is then simply a slice of that history, starting PRE samples before the trigger.
    logic [7:0] hist [2][1024];
    int         hsz [2], tidx [2], evt [2];
    bit         armed [2], trig [2], mdone [2], exp_rv [2];
    logic [7:0] exp_rd [2];
    logic [7:0] mprev = 8'd0;

    function automatic int pre_of(int k);
        return (k == 0) ? PRE0 : PRE1;
    endfunction

    function automatic logic [2:0] exp_state(int k);
        if (mdone[k]) return 3'd4;
        if (!armed[k]) return 3'd0;
        if (trig[k]) return 3'd3;
        return (hsz[k] < pre_of(k)) ? 3'd1 : 3'd2;
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int pre, sz, need;
            bit q;
            pre = pre_of(k);
            need = (tcount == 8'd0) ? 1 : int'(tcount);
            exp_rv[k] = 1'b0;
            exp_rd[k] = 8'd0;
            if (rst) begin
                armed[k] = 0; trig[k] = 0; mdone[k] = 0; hsz[k] = 0; evt[k] = 0;
            end else begin
                if (rd_en && mdone[k]) begin
                    exp_rv[k] = 1'b1;
                    exp_rd[k] = hist[k][tidx[k] - pre + int'(rd_addr)];
                end
                if (arm) begin
                    armed[k] = 1; trig[k] = 0; mdone[k] = 0; hsz[k] = 0; evt[k] = 0;
                end else if (armed[k]) begin
                    sz = hsz[k];
                    if (sz < 1024) hist[k][sz] = probe;
                    hsz[k] = sz + 1;
                    if (sz >= pre && !trig[k]) begin
                        case (mode)
                            2'd0:    q = (probe & mask) == (value & mask);
                            2'd1:    q = (sz > 0) && |(~mprev & probe & mask);
                            2'd2:    q = (sz > 0) && |((mprev ^ probe) & mask);
                            default: q = (sz == pre);
                        endcase
                        if (q) begin
                            evt[k]++;
                            if (evt[k] == need) begin
                                trig[k] = 1;
                                tidx[k] = sz;
                            end
                        end
                    end
                    if (trig[k] && hsz[k] == tidx[k] + D - pre) begin
                        mdone[k] = 1;
                        armed[k] = 0;
                    end
                end
            end
        end
        mprev = rst ? 8'd0 : probe;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("i0 state",     64'(bus0.state_o),     64'(exp_state(0)));
        check("i0 triggered", 64'(bus0.triggered_o), 64'(trig[0]));
        check("i0 done",      64'(bus0.done_o),      64'(mdone[0]));
        check("i0 trig_addr", 64'(bus0.trig_addr_o), trig[0] ? 64'(PRE0) : 64'd0);
        check("i0 rd_valid",  64'(bus0.rd_valid_o),  64'(exp_rv[0]));
        check("i0 rd_data",   64'(bus0.rd_data_o),   64'(exp_rd[0]));
        check("i1 state",     64'(bus1.state_o),     64'(exp_state(1)));
        check("i1 triggered", 64'(bus1.triggered_o), 64'(trig[1]));
        check("i1 done",      64'(bus1.done_o),      64'(mdone[1]));
        check("i1 trig_addr", 64'(bus1.trig_addr_o), trig[1] ? 64'(PRE1) : 64'd0);
        check("i1 rd_valid",  64'(bus1.rd_valid_o),  64'(exp_rv[1]));
        check("i1 rd_data",   64'(bus1.rd_data_o),   64'(exp_rd[1]));
    endtask

    // One clock. The model steps on the edge, outputs are compared on the falling edge,
    // and then the next inputs are driven.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
        case (pgen)
            0:       probe = probe + 8'd1;
            1:       probe = {7'($urandom), ~probe[0]};
            2:       probe = 8'($urandom_range(0, 15));
            default: ;
        endcase
        if (rd_rand) begin
            rd_en   = 1'($urandom);
            rd_addr = 4'($urandom);
        end
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic set_trig(input logic [1:0] md, input logic [7:0] mk, input logic [7:0] vl, input logic [7:0] c);
        mode = md; mask = mk; value = vl; tcount = c;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (!(bus0.done_o && bus1.done_o) && n < budget) begin
            tick();
            n++;
        end
        check("wait_done", 64'(bus0.done_o && bus1.done_o), 64'd1);
    endtask

    // Back-to-back reads. The sequence starts with 15 then 0 to exercise the wrap, then covers the rest.
    task automatic read_all();
        rd_rand = 0;
        rd_en = 1'b1;
        rd_addr = 4'd15; tick();
        rd_addr = 4'd0;  tick();
        for (int a = 1; a < 15; a++) begin
            rd_addr = 4'(a);
            tick();
        end
        rd_en = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        logic [7:0] first;
        probe = 8'd0; mask = 8'd0; value = 8'd0; tcount = 8'd0; mode = 2'd0;
        arm = 1'b1; rd_en = 1'b1; rd_addr = 4'd0; pgen = 3; rd_rand = 0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0; arm = 1'b0; rd_en = 1'b0;
        tick();

        // Level trigger on a counting probe. The window is expected to be 0x1C..0x2B.
        set_trig(2'd0, 8'hFF, 8'h20, 8'd1);
        probe = 8'd0; pgen = 0; rd_rand = 1;
        while (probe != 8'h10) tick();
        arm_pulse();
        wait_done(100, n);
        read_all();
        rd_en = 1'b1; rd_addr = 4'd0; tick();
        check("t1 rd0", 64'(bus0.rd_data_o), 64'h1C);
        rd_addr = 4'd15; tick();
        check("t1 rd15", 64'(bus0.rd_data_o), 64'h2B);
        check("t1 trig_addr", 64'(bus0.trig_addr_o), 64'd4);
        rd_en = 1'b0; tick();

        // Rising edge on bit 0, third occurrence.
        set_trig(2'd1, 8'h01, 8'h00, 8'd3);
        pgen = 1; rd_rand = 1;
        arm_pulse();
        wait_done(100, n);
        read_all();

        // Level match held through the pre-fill is ignored; a later match is taken.
        set_trig(2'd0, 8'hFF, 8'h55, 8'd0);
        probe = 8'h55; pgen = 3; rd_rand = 1;
        arm_pulse();
        tick(); tick(); tick();
        pgen = 2; tick();
        repeat (4) tick();
        probe = 8'h55; pgen = 3;
        wait_done(50, n);
        read_all();
        rd_en = 1'b1; rd_addr = 4'd4; tick();
        check("t3 rd4", 64'(bus0.rd_data_o), 64'h55);
        rd_en = 1'b0; tick();

        // Immediate mode. Both instances freeze after exactly DEPTH writes.
        set_trig(2'd3, 8'h00, 8'h00, 8'd1);
        pgen = 2; rd_rand = 1;
        arm_pulse();
        first = probe;
        wait_done(40, n);
        check("t4 latency", 64'(n), 64'd16);
        read_all();
        rd_en = 1'b1; rd_addr = 4'd0; tick();
        check("t4 rd0", 64'(bus1.rd_data_o), 64'(first));
        rd_en = 1'b0; tick();

        // Re-arm during POST, then reset during WAIT.
        pgen = 0; rd_rand = 1;
        set_trig(2'd0, 8'hFF, probe + 8'd8, 8'd1);
        arm_pulse();
        n = 0;
        while (!bus0.triggered_o && n < 30) begin tick(); n++; end
        check("t5 trig wait", 64'(bus0.triggered_o), 64'd1);
        tick(); tick();
        check("t5 in post", 64'(bus0.state_o), 64'd3);
        arm_pulse();
        check("t5 rearm state", 64'(bus0.state_o), 64'd1);
        check("t5 rearm trig", 64'(bus0.triggered_o), 64'd0);
        set_trig(2'd1, 8'h00, 8'h00, 8'd1);
        repeat (10) tick();
        rst = 1'b1; rd_rand = 0; rd_en = 1'b1;
        tick();
        rst = 1'b0; rd_en = 1'b0;
        tick();

        // Randomised scenarios, with occasional re-arms mid-capture.
        pgen = 2;
        for (int it = 0; it < 12; it++) begin
            set_trig(2'($urandom), ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 15)),
                     8'($urandom_range(0, 15)), 8'($urandom_range(0, 3)));
            rd_rand = 1;
            arm_pulse();
            n = 0;
            while (!(bus0.done_o && bus1.done_o) && n < 60) begin
                if ($urandom_range(0, 29) == 0) arm_pulse();
                else tick();
                n++;
            end
            read_all();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
